// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the multi-channel pulse width meter: channel FSM
// states, default sizing and the channel-index width helper.
package pulse_meter_pkg;

    typedef enum logic [1:0] {
        CH_ARM  = 2'd0,
        CH_IDLE = 2'd1,
        CH_LOW  = 2'd2
    } ch_state_e;

    localparam int DEFAULT_NUM_CH      = 4;
    localparam int DEFAULT_CNT_W       = 12;
    localparam int DEFAULT_SYNC_STAGES = 2;

    function automatic int ch_width(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/pulse_meter_channel.sv
// One measurement channel: input synchronizer, ARM/IDLE/LOW FSM, saturating
// low-phase counter and a single-entry result slot drained by the arbiter.
module pulse_meter_channel
    import pulse_meter_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_async,
    input  logic             drain,
    output logic             busy,
    output logic             slot_pend,
    output logic [CNT_W-1:0] slot_dur,
    output logic             slot_ovf,
    output logic             slot_drop
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s;
    ch_state_e              state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   ovf_reg;
    logic                   capture;

    assign s       = sync_reg[SYNC_STAGES-1];
    assign busy    = (state_reg == CH_LOW);
    assign capture = enable && (state_reg == CH_LOW) && s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig_async};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= CH_ARM;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else if (!enable) begin
            state_reg <= CH_ARM;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                CH_ARM: begin
                    if (s) state_reg <= CH_IDLE;
                end
                CH_IDLE: begin
                    if (!s) begin
                        state_reg <= CH_LOW;
                        cnt_reg   <= CNT_W'(1);
                        ovf_reg   <= 1'b0;
                    end
                end
                CH_LOW: begin
                    if (s) begin
                        state_reg <= CH_IDLE;
                        cnt_reg   <= '0;
                        ovf_reg   <= 1'b0;
                    end else if (cnt_reg == CNT_MAX) begin
                        ovf_reg   <= 1'b1;
                    end else begin
                        cnt_reg   <= cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= CH_ARM;
            endcase
        end
    end

    // A capture racing a drain is not a loss, so drop only flags a true overwrite.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_pend <= 1'b0;
            slot_dur  <= '0;
            slot_ovf  <= 1'b0;
            slot_drop <= 1'b0;
        end else if (capture) begin
            slot_pend <= 1'b1;
            slot_dur  <= cnt_reg;
            slot_ovf  <= ovf_reg;
            slot_drop <= slot_pend && !drain;
        end else if (drain) begin
            slot_pend <= 1'b0;
        end
    end

endmodule

// File: rtl/pulse_width_meter_mc.sv
// Multi-channel low-phase width meter: NUM_CH channels feed a round-robin
// arbiter and a single valid/ready output register.
module pulse_width_meter_mc
    import pulse_meter_pkg::*;
#(
    parameter  int NUM_CH      = DEFAULT_NUM_CH,
    parameter  int CNT_W       = DEFAULT_CNT_W,
    parameter  int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    localparam int CH_W        = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] signal_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [CNT_W-1:0]  out_duration,
    output logic              out_ovf,
    output logic              out_drop,
    output logic [NUM_CH-1:0] busy
);

    logic [NUM_CH-1:0] slot_pend;
    logic [NUM_CH-1:0] slot_ovf;
    logic [NUM_CH-1:0] slot_drop;
    logic [NUM_CH-1:0] drain;
    logic [CNT_W-1:0]  slot_dur [NUM_CH];
    logic [CH_W-1:0]   ptr_reg;
    logic [CH_W-1:0]   grant_idx;
    logic [CH_W-1:0]   cand;
    logic              grant_any;
    logic              load_en;

    assign load_en = !out_valid || out_ready;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            pulse_meter_channel #(
                .CNT_W       (CNT_W),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_ch (
                .clk       (clk),
                .reset     (reset),
                .enable    (enable),
                .sig_async (signal_in[gi]),
                .drain     (drain[gi]),
                .busy      (busy[gi]),
                .slot_pend (slot_pend[gi]),
                .slot_dur  (slot_dur[gi]),
                .slot_ovf  (slot_ovf[gi]),
                .slot_drop (slot_drop[gi])
            );
            assign drain[gi] = load_en && grant_any && (grant_idx == CH_W'(gi));
        end
    endgenerate

    // Scan starts one past the last grant and wraps, so NUM_CH need not be a power of two.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = ptr_reg;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = (cand == CH_W'(NUM_CH - 1)) ? '0 : cand + CH_W'(1);
            if (!grant_any && slot_pend[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_ch       <= '0;
            out_duration <= '0;
            out_ovf      <= 1'b0;
            out_drop     <= 1'b0;
            ptr_reg      <= CH_W'(NUM_CH - 1);
        end else if (load_en) begin
            out_valid <= grant_any;
            if (grant_any) begin
                out_ch       <= grant_idx;
                out_duration <= slot_dur[grant_idx];
                out_ovf      <= slot_ovf[grant_idx];
                out_drop     <= slot_drop[grant_idx];
                ptr_reg      <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_pulse_width_meter_mc.sv
// Bench for pulse_width_meter_mc: directed scenarios plus random pulse trains
// compared against a per-channel run-length reference model.
module tb_pulse_width_meter_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  signal_in;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;
    logic [11:0] out_duration;
    logic        out_ovf;
    logic        out_drop;
    logic [3:0]  busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int ch;
        int dur;
        bit ovf;
        bit drop;
        int cyc;
    } txn_t;

    txn_t obs[$];
    txn_t mon_t;
    bit   stall_seen = 1'b0;
    txn_t held;

    pulse_width_meter_mc #(
        .NUM_CH      (4),
        .CNT_W       (12),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .signal_in    (signal_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ch       (out_ch),
        .out_duration (out_duration),
        .out_ovf      (out_ovf),
        .out_drop     (out_drop),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Transfers are sampled mid-cycle, where valid/ready are settled.
    always @(negedge clk) begin
        if (reset) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen) begin
                check_val("hold_valid", 32'(out_valid), 32'd1);
                check_val("hold_ch", 32'(out_ch), 32'(held.ch));
                check_val("hold_dur", 32'(out_duration), 32'(held.dur));
                check_val("hold_ovf", 32'(out_ovf), 32'(held.ovf));
                check_val("hold_drop", 32'(out_drop), 32'(held.drop));
            end
            if (out_valid && out_ready) begin
                mon_t.ch   = int'(out_ch);
                mon_t.dur  = int'(out_duration);
                mon_t.ovf  = out_ovf;
                mon_t.drop = out_drop;
                mon_t.cyc  = cyc;
                obs.push_back(mon_t);
                $display("TXN cyc=%0d ch=%0d dur=%0d ovf=%0d drop=%0d",
                         cyc, out_ch, out_duration, out_ovf, out_drop);
            end
            stall_seen = out_valid && !out_ready;
            if (stall_seen) begin
                held.ch   = int'(out_ch);
                held.dur  = int'(out_duration);
                held.ovf  = out_ovf;
                held.drop = out_drop;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int ch, input int n);
        signal_in[ch] = 1'b0;
        tick(n);
        signal_in[ch] = 1'b1;
    endtask

    task automatic expect_txn(input string tag, input int idx, input int ch, input int dur,
                              input bit ovf, input bit drop);
        if (idx < obs.size()) begin
            check_val({tag, "_ch"}, 32'(obs[idx].ch), 32'(ch));
            check_val({tag, "_dur"}, 32'(obs[idx].dur), 32'(dur));
            check_val({tag, "_ovf"}, 32'(obs[idx].ovf), 32'(ovf));
            check_val({tag, "_drop"}, 32'(obs[idx].drop), 32'(drop));
        end else begin
            check_val({tag, "_missing"}, 32'(obs.size()), 32'(idx + 1));
        end
    endtask

    int   t_rise;
    int   rem [4];
    bit   lvl [4];
    int   lowlen [4];
    int   expq [4][$];
    int   e;
    txn_t tr;

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        out_ready = 1'b1;
        signal_in = 4'b1110;
        tick(3);
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_ch", 32'(out_ch), 32'd0);
        check_val("rst_dur", 32'(out_duration), 32'd0);
        check_val("rst_ovf", 32'(out_ovf), 32'd0);
        check_val("rst_drop", 32'(out_drop), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // ch0 already low at reset release: that partial phase must not report
        tick(40);
        check_val("arm_busy", 32'(busy), 32'd0);
        signal_in[0] = 1'b1;
        tick(20);
        signal_in[0] = 1'b0;
        tick(30);
        check_val("low_busy", 32'(busy), 32'd1);
        tick(20);
        signal_in[0] = 1'b1;
        tick(20);
        check_val("arm_count", 32'(obs.size()), 32'd1);
        expect_txn("arm", 0, 0, 50, 1'b0, 1'b0);

        // saturation
        obs.delete();
        pulse(2, 5000);
        tick(20);
        check_val("sat_count", 32'(obs.size()), 32'd1);
        expect_txn("sat", 0, 2, 4095, 1'b1, 1'b0);

        // basic measurement and latency
        obs.delete();
        signal_in[0] = 1'b0;
        tick(100);
        t_rise = cyc;
        signal_in[0] = 1'b1;
        tick(20);
        check_val("basic_count", 32'(obs.size()), 32'd1);
        expect_txn("basic", 0, 0, 100, 1'b0, 1'b0);
        if (obs.size() > 0) check_val("basic_lat", 32'(obs[0].cyc), 32'(t_rise + 4));

        // three channels finishing together
        obs.delete();
        signal_in[3] = 1'b0;
        tick(10);
        signal_in[2] = 1'b0;
        tick(10);
        signal_in[1] = 1'b0;
        tick(30);
        signal_in = 4'b1111;
        tick(20);
        check_val("rr_count", 32'(obs.size()), 32'd3);
        expect_txn("rr0", 0, 1, 30, 1'b0, 1'b0);
        expect_txn("rr1", 1, 2, 40, 1'b0, 1'b0);
        expect_txn("rr2", 2, 3, 50, 1'b0, 1'b0);
        if (obs.size() == 3) begin
            check_val("rr_gap1", 32'(obs[1].cyc - obs[0].cyc), 32'd1);
            check_val("rr_gap2", 32'(obs[2].cyc - obs[1].cyc), 32'd1);
        end

        // backpressure with overwrite
        obs.delete();
        out_ready = 1'b0;
        pulse(0, 10);
        tick(8);
        check_val("stall_valid", 32'(out_valid), 32'd1);
        check_val("stall_dur", 32'(out_duration), 32'd10);
        pulse(0, 20);
        tick(8);
        pulse(0, 30);
        tick(13);
        out_ready = 1'b1;
        tick(10);
        check_val("drop_count", 32'(obs.size()), 32'd2);
        expect_txn("drop0", 0, 0, 10, 1'b0, 1'b0);
        expect_txn("drop1", 1, 0, 30, 1'b0, 1'b1);

        // reset mid-pulse with a stalled result present
        obs.delete();
        out_ready = 1'b0;
        pulse(1, 6);
        tick(8);
        check_val("pre_rst_valid", 32'(out_valid), 32'd1);
        signal_in[0] = 1'b0;
        tick(10);
        check_val("pre_rst_busy", 32'(busy[0]), 32'd1);
        reset = 1'b1;
        #1;
        check_val("async_valid", 32'(out_valid), 32'd0);
        check_val("async_dur", 32'(out_duration), 32'd0);
        check_val("async_busy", 32'(busy), 32'd0);
        tick(3);
        reset = 1'b0;
        out_ready = 1'b1;
        tick(5);
        signal_in[0] = 1'b1;
        tick(20);
        check_val("stale_count", 32'(obs.size()), 32'd0);

        // enable dropout during a ch1 low phase
        obs.delete();
        out_ready = 1'b0;
        pulse(3, 7);
        tick(8);
        pulse(0, 15);
        tick(8);
        signal_in[1] = 1'b0;
        tick(10);
        check_val("en_busy", 32'(busy), 32'd2);
        enable = 1'b0;
        tick(1);
        check_val("dis_busy", 32'(busy), 32'd0);
        tick(4);
        enable = 1'b1;
        tick(10);
        signal_in[1] = 1'b1;
        tick(5);
        out_ready = 1'b1;
        tick(15);
        check_val("en_count", 32'(obs.size()), 32'd2);
        expect_txn("en0", 0, 3, 7, 1'b0, 1'b0);
        expect_txn("en1", 1, 0, 15, 1'b0, 1'b0);

        // random pulse trains; runs of >=4 cycles keep each slot drained in time
        obs.delete();
        for (int c = 0; c < 4; c++) begin
            lvl[c]    = 1'b1;
            rem[c]    = int'($urandom_range(4, 20));
            lowlen[c] = 0;
        end
        repeat (800) begin
            for (int c = 0; c < 4; c++) signal_in[c] = lvl[c];
            tick(1);
            for (int c = 0; c < 4; c++) begin
                if (!lvl[c]) begin
                    lowlen[c]++;
                end else begin
                    if (lowlen[c] > 0) expq[c].push_back(lowlen[c]);
                    lowlen[c] = 0;
                end
                rem[c]--;
                if (rem[c] == 0) begin
                    lvl[c] = !lvl[c];
                    rem[c] = int'($urandom_range(4, 40));
                end
            end
        end
        signal_in = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            if (lowlen[c] > 0) expq[c].push_back(lowlen[c]);
        end
        tick(40);
        foreach (obs[i]) begin
            tr = obs[i];
            if (expq[tr.ch].size() > 0) begin
                e = expq[tr.ch].pop_front();
                check_val("rnd_dur", 32'(tr.dur), 32'((e > 4095) ? 4095 : e));
                check_val("rnd_ovf", 32'(tr.ovf), 32'(e > 4095));
                check_val("rnd_drop", 32'(tr.drop), 32'd0);
            end else begin
                check_val("rnd_extra", 32'd1, 32'd0);
            end
        end
        for (int c = 0; c < 4; c++) check_val("rnd_left", 32'(expq[c].size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
